// File: rtl/fr_lane_queue.sv
// fr_lane_queue
//   Per-lane car queue for the farm-road intersection. An asynchronous
//   "add car" key is synchronized and debounced. Each accepted press adds
//   one car to a saturating 0..15 counter. A two-state dispatch FSM
//   releases one car at a time to the downstream animation, with a minimum
//   idle gap between releases.
//
//   Parameters
//     DEBOUNCE_CYCLES  cycles a synchronized key level must hold (1..65535)
//     DISPATCH_GAP     idle cycles between two dispatches (1..255)
//
//   Ports
//     clk               system clock, rising edge
//     reset             asynchronous active-high reset
//     add_raw_i         raw active-high add request (asynchronous)
//     farm_green_i      farm road light for this lane is green
//     dispatch_ready_i  animation can accept a car at the lane entry pixel
//     dispatch_o        one-cycle pulse releasing one queued car
//     count_o           cars waiting, 0..15
//     car_pending_o     count_o != 0
//     overflow_o        sticky dropped-car flag (only with FR_QUEUE_OVF_EN)
//
//   Build option
//     FR_QUEUE_OVF_EN   adds overflow_o and its flop
module fr_lane_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DISPATCH_GAP    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_raw_i,
    input  logic       farm_green_i,
    input  logic       dispatch_ready_i,
    output logic       dispatch_o,
    output logic [3:0] count_o,
    output logic       car_pending_o
`ifdef FR_QUEUE_OVF_EN
    ,
    output logic       overflow_o
`endif
);

    typedef enum logic [0:0] {
        IDLE,
        GAP
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  GAP_LOAD = 8'(DISPATCH_GAP);

    logic        sync1;
    logic        sync2;
    logic        deb_level;
    logic        deb_prev;
    logic [15:0] deb_cnt;
    logic        add_evt;
    logic        disp_fire;
    state_t      state;
    logic [7:0]  gap_cnt;
    logic [3:0]  count;

    // Two-flop synchronizer for the asynchronous key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= add_raw_i;
            sync2 <= sync1;
        end
    end

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive cycle
    // of disagreement; any agreement in between restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_level;
            if (sync2 != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 16'd1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // One add per rising edge of the debounced level; holding adds nothing.
    always_comb begin
        add_evt   = deb_level & ~deb_prev;
        disp_fire = (state == IDLE) && farm_green_i && dispatch_ready_i
                    && (count != 4'd0);
    end

    // Dispatch FSM. The gap counter returns to IDLE on the edge it reaches
    // zero, so successive pulses are DISPATCH_GAP+1 cycles apart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            dispatch_o <= 1'b0;
        end else begin
            dispatch_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (disp_fire) begin
                        dispatch_o <= 1'b1;
                        gap_cnt    <= GAP_LOAD;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gap_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Queue counter: simultaneous add and dispatch cancel out; adds at 15
    // are dropped rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (add_evt && !disp_fire) begin
            if (count != 4'hF) begin
                count <= count + 4'd1;
            end
        end else if (disp_fire && !add_evt) begin
            count <= count - 4'd1;
        end
    end

`ifdef FR_QUEUE_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_o <= 1'b0;
        end else if (add_evt && !disp_fire && (count == 4'hF)) begin
            overflow_o <= 1'b1;
        end
    end
`endif

    assign count_o       = count;
    assign car_pending_o = (count != 4'd0);

endmodule

// File: tb/tb_fr_lane_queue.sv
module tb_fr_lane_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       add_raw = 1'b0;
    logic       farm_green = 1'b0;
    logic       dispatch_ready = 1'b0;
    logic       dispatch;
    logic [3:0] count;
    logic       car_pending;
`ifdef FR_QUEUE_OVF_EN
    logic       overflow;
`endif

    fr_lane_queue #(
        .DEBOUNCE_CYCLES(4),
        .DISPATCH_GAP   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .add_raw_i       (add_raw),
        .farm_green_i    (farm_green),
        .dispatch_ready_i(dispatch_ready),
        .dispatch_o      (dispatch),
        .count_o         (count),
        .car_pending_o   (car_pending)
`ifdef FR_QUEUE_OVF_EN
        ,
        .overflow_o      (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;   // -1: any cycle
        logic disp;
        int   cnt;
    } ev_t;

    ev_t exp_q[$];

    int mon_tests = 0;
    int mon_fails = 0;
    int dir_tests = 0;
    int dir_fails = 0;

    // Monitor: every visible change (dispatch pulse or count change) must
    // match the next expected event.
    logic [3:0] prev_count = 4'd0;
    always @(negedge clk) begin
        if (reset) begin
            prev_count = count;
        end else if (dispatch || count != prev_count) begin
            mon_tests++;
            if (exp_q.size() == 0) begin
                mon_fails++;
                $display("FAIL unexpected_event cyc=%0d dispatch=%0b count=%0d", cyc, dispatch, count);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((e.cyc >= 0 && e.cyc != cyc) || dispatch !== e.disp ||
                    count !== 4'(e.cnt) || car_pending !== (e.cnt != 0)) begin
                    mon_fails++;
                    $display("FAIL event: got cyc=%0d disp=%0b cnt=%0d pend=%0b, expected cyc=%0d disp=%0b cnt=%0d pend=%0b",
                             cyc, dispatch, count, car_pending, e.cyc, e.disp, e.cnt, (e.cnt != 0));
                end
            end
            prev_count = count;
        end
    end

    task automatic expect_ev(input int c, input logic d, input int n);
        ev_t e;
        e.cyc  = c;
        e.disp = d;
        e.cnt  = n;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        dir_tests++;
        if (got != want) begin
            dir_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Clean press: well beyond the debounce window both high and low.
    task automatic press();
        add_raw = 1'b1;
        repeat (8) @(negedge clk);
        add_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    int k;

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_count", count, 0);
        check("reset_dispatch", dispatch, 0);
        check("reset_pending", car_pending, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Short glitch: no add.
        add_raw = 1'b1;
        repeat (2) @(negedge clk);
        add_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_count", count, 0);

        // Held key: one add exactly DEBOUNCE_CYCLES+2 edges after it is seen.
        k = cyc;
        expect_ev(k + 7, 1'b0, 1);
        add_raw = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_count_at_release", count, 1);
        add_raw = 1'b0;
        repeat (10) @(negedge clk);

        // Three presses with red light, then dispatch at 4-cycle spacing.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            expect_ev(-1, 1'b0, i);
            press();
        end
        check("three_count", count, 3);
        check("three_pending", car_pending, 1);
        farm_green = 1'b1;
        dispatch_ready = 1'b0;
        repeat (5) @(negedge clk);
        k = cyc;
        expect_ev(k + 1, 1'b1, 2);
        expect_ev(k + 5, 1'b1, 1);
        expect_ev(k + 9, 1'b1, 0);
        dispatch_ready = 1'b1;
        repeat (14) @(negedge clk);
        check("drain_count", count, 0);
        check("drain_pending", car_pending, 0);
        farm_green = 1'b0;

        // Saturation at 15.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            if (i <= 15) expect_ev(-1, 1'b0, i);
            press();
`ifdef FR_QUEUE_OVF_EN
            if (i == 15) check("ovf_before_drop", overflow, 0);
            if (i == 16) check("ovf_after_drop", overflow, 1);
`endif
        end
        check("sat_count", count, 15);

        // Add and dispatch on the same edge at 15.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            expect_ev(-1, 1'b0, i);
            press();
        end
        k = cyc;
        expect_ev(k + 7, 1'b1, 15);
        add_raw = 1'b1;
        repeat (6) @(negedge clk);
        farm_green = 1'b1;
        dispatch_ready = 1'b1;
        @(negedge clk);
        farm_green = 1'b0;
        repeat (10) @(negedge clk);
        add_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("coincide_count", count, 15);
`ifdef FR_QUEUE_OVF_EN
        check("coincide_ovf", overflow, 0);
`endif

        // Reset mid-GAP discards everything, no pulse afterwards.
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            expect_ev(-1, 1'b0, i);
            press();
        end
        k = cyc;
        expect_ev(k + 1, 1'b1, 1);
        farm_green = 1'b1;
        dispatch_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midgap_reset_count", count, 0);
        check("midgap_reset_dispatch", dispatch, 0);
        check("midgap_reset_pending", car_pending, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("after_reset_count", count, 0);
        farm_green = 1'b0;
        repeat (2) @(negedge clk);

        check("events_left_unseen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", mon_tests + dir_tests, mon_fails + dir_fails);
        $finish;
    end

endmodule
